// File: rtl/ps2_host_fifo.sv
// PS/2 host controller: synchronised line sampling, receive framing with an
// odd-parity/stop check, a show-ahead receive FIFO, a frame watchdog and a
// host-to-device transmit sequence with an ACK/NACK status handshake.
module ps2_host_fifo #(
  parameter int INHIBIT_CYCLES = 8191,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk_d,
  input  logic               ps2_data_d,
  output logic               ps2_clk_q,
  output logic               ps2_data_q,
  input  logic [7:0]         tx_data,
  input  logic               tx_req,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_err,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_rd,
  output logic [FIFO_AW:0]   rx_count,
  output logic               rx_err,
  output logic               rx_overflow
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_DATA, TX_ACK} state_t;

  state_t             state;
  logic               clk_p0, clk_p1, clk_p2;
  logic               data_p0, data_p1, data_s;
  logic               fall;
  logic [3:0]         bit_cnt;
  logic [INH_W-1:0]   inh_cnt;
  logic [WD_W-1:0]    wdog;
  logic [8:0]         rx_shift;
  logic [9:0]         tx_shift;
  logic [9:0]         rx_word;
  logic               frame_done, frame_ok, pop, full, push, wdog_zero;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         mem [FIFO_DEPTH];

  // True when the 9 bits (data + parity) hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] w);
    return ^w;
  endfunction

  // Parity bit that makes data + parity odd.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ~^d;
  endfunction

  // Two-flop synchronisers plus one history stage; data_s lines up with fall.
  always_ff @(posedge clk) begin
    clk_p0  <= ps2_clk_d;
    clk_p1  <= clk_p0;
    clk_p2  <= clk_p1;
    data_p0 <= ps2_data_d;
    data_p1 <= data_p0;
    data_s  <= data_p1;
  end

  // Registered falling-edge strobe of the synchronised PS/2 clock.
  always_ff @(posedge clk) begin
    if (!rst) fall <= 1'b0;
    else      fall <= clk_p2 & ~clk_p1;
  end

  // Frame word as it stands on the stop-bit edge: {stop, parity, d7..d0}.
  assign rx_word    = {data_s, rx_shift};
  assign frame_done = (state == RX) && fall && (bit_cnt == 4'd9);
  assign frame_ok   = odd_parity_ok(rx_word[8:0]) & rx_word[9];
  assign pop        = rx_rd & rx_valid;
  assign full       = (rx_count == (FIFO_AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = frame_done & frame_ok & (~full | pop);
  assign wdog_zero  = (wdog == '0);

  // Protocol FSM: receive framing, transmit sequencing, watchdog and pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      rx_err      <= 1'b0;
      rx_overflow <= 1'b0;
      ps2_clk_q   <= 1'b0;
      ps2_data_q  <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      wdog        <= '0;
    end else begin
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      rx_err      <= 1'b0;
      rx_overflow <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_q  <= 1'b0;
          ps2_data_q <= 1'b0;
          if (tx_req) begin
            state     <= TX_INH;
            tx_busy   <= 1'b1;
            ps2_clk_q <= 1'b1;
            inh_cnt   <= INH_W'(1);
            // Start bit is driven separately at the end of the inhibit.
            tx_shift  <= {1'b1, odd_parity_bit(tx_data), tx_data};
          end else if (fall && !data_s) begin
            state   <= RX;
            bit_cnt <= '0;
            wdog    <= WD_W'(TIMEOUT_CYCLES);
          end
        end
        RX: begin
          if (fall) begin
            rx_shift <= rx_word[9:1];
            wdog     <= WD_W'(TIMEOUT_CYCLES);
            if (bit_cnt == 4'd9) begin
              state       <= IDLE;
              rx_err      <= ~frame_ok;
              rx_overflow <= frame_ok & ~push;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (wdog_zero) begin
            rx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        TX_INH: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES)) begin
            ps2_clk_q <= 1'b0;
            state     <= TX_DATA;
            bit_cnt   <= '0;
            wdog      <= WD_W'(TIMEOUT_CYCLES);
          end else begin
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) ps2_data_q <= 1'b1;
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (fall) begin
            ps2_data_q <= ~tx_shift[0];
            tx_shift   <= {1'b1, tx_shift[9:1]};
            wdog       <= WD_W'(TIMEOUT_CYCLES);
            if (bit_cnt == 4'd9) state <= TX_ACK;
            else                 bit_cnt <= bit_cnt + 4'd1;
          end else if (wdog_zero) begin
            tx_err     <= 1'b1;
            tx_busy    <= 1'b0;
            ps2_data_q <= 1'b0;
            state      <= IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        TX_ACK: begin
          ps2_data_q <= 1'b0;
          if (fall) begin
            tx_done <= ~data_s;
            tx_err  <= data_s;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else if (wdog_zero) begin
            tx_err  <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      rx_count <= rx_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_word[7:0];
  end

  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
